// File: rtl/oflow_score_pkg.sv
// Shared types for the optical-flow score/minimum path.
// Default widths, slot record, FSM state encoding.
package oflow_score_pkg;

  localparam int SCORE_LEN = 16;
  localparam int ID_LEN    = 12;

  localparam logic [SCORE_LEN-1:0] SCORE_MAX = '1;

  typedef struct packed {
    logic [SCORE_LEN-1:0] score;
    logic [ID_LEN-1:0]    id;
  } score_slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_MERGE,
    ST_DONE
  } score_state_e;

endpackage

// File: rtl/oflow_topk_insert.sv
// Combinational insertion of one candidate into a sorted
// TOP_K slot array; empty slots (id 0) always accept.
module oflow_topk_insert #(
  parameter int TOP_K     = 2,
  parameter int SCORE_LEN = 16,
  parameter int ID_LEN    = 12
) (
  input  logic [TOP_K*SCORE_LEN-1:0] slot_score_i,
  input  logic [TOP_K*ID_LEN-1:0]    slot_id_i,
  input  logic                       cand_en_i,
  input  logic [SCORE_LEN-1:0]       cand_score_i,
  input  logic [ID_LEN-1:0]          cand_id_i,
  output logic [TOP_K*SCORE_LEN-1:0] slot_score_o,
  output logic [TOP_K*ID_LEN-1:0]    slot_id_o,
  output logic                       count_inc_o
);

  logic                 placed;
  logic [SCORE_LEN-1:0] prev_s, cur_s;
  logic [ID_LEN-1:0]    prev_i, cur_i;

  // Strict '>' keeps earlier arrivals ahead of equal scores.
  always_comb begin
    slot_score_o = slot_score_i;
    slot_id_o    = slot_id_i;
    placed       = 1'b0;
    prev_s       = '0;
    prev_i       = '0;
    cur_s        = '0;
    cur_i        = '0;
    for (int j = 0; j < TOP_K; j++) begin
      cur_s = slot_score_i[j*SCORE_LEN +: SCORE_LEN];
      cur_i = slot_id_i[j*ID_LEN +: ID_LEN];
      if (placed) begin
        slot_score_o[j*SCORE_LEN +: SCORE_LEN] = prev_s;
        slot_id_o[j*ID_LEN +: ID_LEN]          = prev_i;
      end else if (cand_en_i &&
                   (cur_i == '0 || cur_s > cand_score_i)) begin
        slot_score_o[j*SCORE_LEN +: SCORE_LEN] = cand_score_i;
        slot_id_o[j*ID_LEN +: ID_LEN]          = cand_id_i;
        placed = 1'b1;
      end
      prev_s = cur_s;
      prev_i = cur_i;
    end
    count_inc_o = cand_en_i &&
      (slot_id_i[(TOP_K-1)*ID_LEN +: ID_LEN] == '0);
  end

endmodule

// File: rtl/oflow_score_calc_min_n.sv
// Top-K minimum score merge over NUM_LANES-wide buffer lines.
// One lane merged per cycle; requests the next line itself.
module oflow_score_calc_min_n #(
  parameter int NUM_LANES = 2,
  parameter int TOP_K     = 2,
  parameter int SCORE_LEN = oflow_score_pkg::SCORE_LEN,
  parameter int ID_LEN    = oflow_score_pkg::ID_LEN,
  parameter int CW        = $clog2(TOP_K+1)
) (
  input  logic                           clk,
  input  logic                           reset_N,
  input  logic                           start_score_calc,
  input  logic [SCORE_LEN-1:0]           score_thresh,
  input  logic                           line_valid,
  input  logic                           line_last,
  input  logic [NUM_LANES-1:0]           lane_valid,
  input  logic [NUM_LANES*SCORE_LEN-1:0] lane_score,
  input  logic [NUM_LANES*ID_LEN-1:0]    lane_id,
  output logic                           read_new_line,
  output logic [TOP_K*SCORE_LEN-1:0]     min_score,
  output logic [TOP_K*ID_LEN-1:0]        min_id,
  output logic [CW-1:0]                  min_count,
  output logic                           done_score_calc,
  output logic                           busy,
  output logic                           line_overrun
);
  import oflow_score_pkg::*;

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  score_state_e state_q, state_d;
  logic [SCORE_LEN-1:0]           thresh_q, thresh_d;
  logic [NUM_LANES-1:0]           lv_q, lv_d;
  logic [NUM_LANES*SCORE_LEN-1:0] ls_q, ls_d;
  logic [NUM_LANES*ID_LEN-1:0]    li_q, li_d;
  logic                           last_q, last_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [TOP_K*SCORE_LEN-1:0]     ms_q, ms_d;
  logic [TOP_K*ID_LEN-1:0]        mi_q, mi_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic rnl_q, rnl_d, done_q, done_d, ovr_q, ovr_d;

  logic [SCORE_LEN-1:0]       c_score;
  logic [ID_LEN-1:0]          c_id;
  logic                       c_valid, c_en, c_inc;
  logic [TOP_K*SCORE_LEN-1:0] ins_s;
  logic [TOP_K*ID_LEN-1:0]    ins_i;

  // Select the lane under merge and qualify it.
  always_comb begin
    c_score = '0;
    c_id    = '0;
    c_valid = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx_q == IW'(i)) begin
        c_score = ls_q[i*SCORE_LEN +: SCORE_LEN];
        c_id    = li_q[i*ID_LEN +: ID_LEN];
        c_valid = lv_q[i];
      end
    end
    c_en = (state_q == ST_MERGE) && c_valid &&
           (c_id != '0) && (c_score <= thresh_q);
  end

  oflow_topk_insert #(
    .TOP_K    (TOP_K),
    .SCORE_LEN(SCORE_LEN),
    .ID_LEN   (ID_LEN)
  ) u_ins (
    .slot_score_i(ms_q),
    .slot_id_i   (mi_q),
    .cand_en_i   (c_en),
    .cand_score_i(c_score),
    .cand_id_i   (c_id),
    .slot_score_o(ins_s),
    .slot_id_o   (ins_i),
    .count_inc_o (c_inc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    thresh_d = thresh_q;
    lv_d     = lv_q;
    ls_d     = ls_q;
    li_d     = li_q;
    last_d   = last_q;
    idx_d    = idx_q;
    ms_d     = ms_q;
    mi_d     = mi_q;
    cnt_d    = cnt_q;
    rnl_d    = 1'b0;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (start_score_calc) begin
          ms_d     = '1;
          mi_d     = '0;
          cnt_d    = '0;
          ovr_d    = 1'b0;
          thresh_d = score_thresh;
          state_d  = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        if (line_valid) begin
          lv_d    = lane_valid;
          ls_d    = lane_score;
          li_d    = lane_id;
          last_d  = line_last;
          idx_d   = '0;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        ms_d  = ins_s;
        mi_d  = ins_i;
        cnt_d = cnt_q + CW'(c_inc);
        if (idx_q == IW'(NUM_LANES-1)) begin
          if (last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_LINE;
            rnl_d   = 1'b1;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (line_valid && state_q != ST_WAIT_LINE) ovr_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state_q  <= ST_IDLE;
      thresh_q <= '0;
      lv_q     <= '0;
      ls_q     <= '0;
      li_q     <= '0;
      last_q   <= 1'b0;
      idx_q    <= '0;
      ms_q     <= '1;
      mi_q     <= '0;
      cnt_q    <= '0;
      rnl_q    <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      thresh_q <= thresh_d;
      lv_q     <= lv_d;
      ls_q     <= ls_d;
      li_q     <= li_d;
      last_q   <= last_d;
      idx_q    <= idx_d;
      ms_q     <= ms_d;
      mi_q     <= mi_d;
      cnt_q    <= cnt_d;
      rnl_q    <= rnl_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign read_new_line   = rnl_q;
  assign min_score       = ms_q;
  assign min_id          = mi_q;
  assign min_count       = cnt_q;
  assign done_score_calc = done_q;
  assign line_overrun    = ovr_q;
  assign busy = (state_q == ST_WAIT_LINE) ||
                (state_q == ST_MERGE);

endmodule

// File: tb/tb_oflow_score_calc_min_n.sv
// Directed bench for oflow_score_calc_min_n.
// Two instances: 2 lanes and 4 lanes, both TOP_K=2.
module tb_oflow_score_calc_min_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst2, start2, lv2, last2;
  logic [15:0] th2;
  logic [1:0]  lanev2;
  logic [31:0] lsc2;
  logic [23:0] lid2;
  logic        rnl2, done2, busy2, ovr2;
  logic [31:0] ms2;
  logic [23:0] mi2;
  logic [1:0]  cnt2;

  logic        rst4, start4, lv4, last4;
  logic [15:0] th4;
  logic [3:0]  lanev4;
  logic [63:0] lsc4;
  logic [47:0] lid4;
  logic        rnl4, done4, busy4, ovr4;
  logic [31:0] ms4;
  logic [23:0] mi4;
  logic [1:0]  cnt4;

  oflow_score_calc_min_n #(.NUM_LANES(2), .TOP_K(2)) dut2 (
    .clk(clk), .reset_N(rst2), .start_score_calc(start2),
    .score_thresh(th2), .line_valid(lv2), .line_last(last2),
    .lane_valid(lanev2), .lane_score(lsc2), .lane_id(lid2),
    .read_new_line(rnl2), .min_score(ms2), .min_id(mi2),
    .min_count(cnt2), .done_score_calc(done2), .busy(busy2),
    .line_overrun(ovr2)
  );

  oflow_score_calc_min_n #(.NUM_LANES(4), .TOP_K(2)) dut4 (
    .clk(clk), .reset_N(rst4), .start_score_calc(start4),
    .score_thresh(th4), .line_valid(lv4), .line_last(last4),
    .lane_valid(lanev4), .lane_score(lsc4), .lane_id(lid4),
    .read_new_line(rnl4), .min_score(ms4), .min_id(mi4),
    .min_count(cnt4), .done_score_calc(done4), .busy(busy4),
    .line_overrun(ovr4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start_2(input logic [15:0] th);
    @(negedge clk);
    start2 = 1'b1;
    th2    = th;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic send2(input string tag,
                       input logic [1:0] v,
                       input logic [15:0] s0, s1,
                       input logic [11:0] i0, i1,
                       input logic last);
    logic got;
    @(negedge clk);
    lv2 = 1'b1; lanev2 = v; last2 = last;
    lsc2 = {s1, s0}; lid2 = {i1, i0};
    @(negedge clk);
    lv2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (last ? done2 : rnl2) got = 1'b1;
      else @(negedge clk);
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  int rnl_cnt, rnl_at, done_cnt, done_at;

  initial begin
    rst2 = 1'b1; start2 = 0; lv2 = 0; last2 = 0;
    th2 = '0; lanev2 = '0; lsc2 = '0; lid2 = '0;
    rst4 = 1'b1; start4 = 0; lv4 = 0; last4 = 0;
    th4 = '0; lanev4 = '0; lsc4 = '0; lid4 = '0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0; rst4 = 1'b0;
    @(negedge clk);

    chk("rst_score", 64'(ms2), 64'hFFFF_FFFF);
    chk("rst_id", 64'(mi2), 64'd0);
    chk("rst_count", 64'(cnt2), 64'd0);
    chk("rst_flags", 64'({rnl2, done2, busy2, ovr2}), 64'd0);

    // Basic two-line run with cycle-accurate timing.
    start_2(16'hFFFF);
    rnl_cnt = 0; rnl_at = -1; done_cnt = 0; done_at = -1;
    chk("busy_wait", 64'(busy2), 64'd1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      if (rnl2) begin rnl_cnt++; rnl_at = k; end
      if (done2) begin done_cnt++; done_at = k; end
      lv2 = (k == 0 || k == 3);
      lanev2 = 2'b11;
      last2 = (k == 3);
      lsc2 = (k == 0) ? {16'd10, 16'd30} : {16'd40, 16'd20};
      lid2 = (k == 0) ? {12'd7, 12'd5} : {12'd3, 12'd9};
    end
    lv2 = 1'b0;
    chk("rnl_pulses", 64'(rnl_cnt), 64'd1);
    chk("rnl_cycle", 64'(rnl_at), 64'd3);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("done_cycle", 64'(done_at), 64'd6);
    chk("basic_score", 64'(ms2), {32'd0, 16'd20, 16'd10});
    chk("basic_id", 64'(mi2), {40'd0, 12'd9, 12'd7});
    chk("basic_count", 64'(cnt2), 64'd2);
    chk("basic_idle", 64'(busy2), 64'd0);

    // Equal scores: earlier lane keeps slot 0.
    start_2(16'hFFFF);
    send2("tie_done", 2'b11, 16'd15, 16'd15, 12'd1, 12'd2, 1'b1);
    chk("tie_id", 64'(mi2), {40'd0, 12'd2, 12'd1});
    chk("tie_score", 64'(ms2), {32'd0, 16'd15, 16'd15});
    @(negedge clk);
    chk("done_one_cycle", 64'(done2), 64'd0);

    // Threshold, id 0 and lane_valid filtering.
    start_2(16'd50);
    send2("filt_l1", 2'b11, 16'd60, 16'd25, 12'd4, 12'd0, 1'b0);
    send2("filt_done", 2'b00, 16'd45, 16'd45, 12'd6, 12'd6, 1'b1);
    chk("filt_count", 64'(cnt2), 64'd0);
    chk("filt_score", 64'(ms2), 64'hFFFF_FFFF);
    chk("filt_id", 64'(mi2), 64'd0);

    // Score equal to threshold is kept, one above is not.
    start_2(16'd50);
    send2("thr_done", 2'b11, 16'd50, 16'd51, 12'd8, 12'd9, 1'b1);
    chk("thr_count", 64'(cnt2), 64'd1);
    chk("thr_score", 64'(ms2), {32'd0, 16'hFFFF, 16'd50});
    chk("thr_id", 64'(mi2), {40'd0, 12'd0, 12'd8});

    // Overflow on the four-lane instance.
    @(negedge clk);
    start4 = 1'b1; th4 = 16'hFFFF;
    @(negedge clk);
    start4 = 1'b0;
    lv4 = 1'b1; last4 = 1'b1; lanev4 = 4'hF;
    lsc4 = {16'd3, 16'd5, 16'd7, 16'd9};
    lid4 = {12'd4, 12'd3, 12'd2, 12'd1};
    @(negedge clk);
    lv4 = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 20 && done_cnt == 0; c++) begin
      if (done4) done_cnt++;
      else @(negedge clk);
    end
    chk("ovf_done", 64'(done_cnt), 64'd1);
    chk("ovf_score", 64'(ms4), {32'd0, 16'd5, 16'd3});
    chk("ovf_id", 64'(mi4), {40'd0, 12'd3, 12'd4});
    chk("ovf_count", 64'(cnt4), 64'd2);

    // line_valid during MERGE, then start during WAIT_LINE.
    start_2(16'hFFFF);
    lv2 = 1'b1; lanev2 = 2'b11; last2 = 1'b0;
    lsc2 = {16'd10, 16'd30}; lid2 = {12'd7, 12'd5};
    @(negedge clk);
    lsc2 = {16'd1, 16'd1}; lid2 = {12'd12, 12'd11};
    last2 = 1'b1;
    @(negedge clk);
    lv2 = 1'b0;
    rnl_cnt = 0;
    for (int c = 0; c < 20 && rnl_cnt == 0; c++) begin
      if (rnl2) rnl_cnt++;
      else @(negedge clk);
    end
    chk("ovr_rnl", 64'(rnl_cnt), 64'd1);
    chk("ovr_flag", 64'(ovr2), 64'd1);
    chk("ovr_list", 64'(mi2), {40'd0, 12'd5, 12'd7});
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("ign_busy", 64'(busy2), 64'd1);
    chk("ign_count", 64'(cnt2), 64'd2);
    send2("ign_done", 2'b11, 16'd50, 16'd60, 12'd1, 12'd2, 1'b1);
    chk("ign_score", 64'(ms2), {32'd0, 16'd30, 16'd10});
    chk("ign_id", 64'(mi2), {40'd0, 12'd5, 12'd7});
    chk("ovr_sticky", 64'(ovr2), 64'd1);
    start_2(16'hFFFF);
    chk("ovr_clear", 64'(ovr2), 64'd0);
    chk("restart_count", 64'(cnt2), 64'd0);

    // Reset in MERGE: back to IDLE, no done pulse.
    lv2 = 1'b1; lanev2 = 2'b11; last2 = 1'b1;
    lsc2 = {16'd10, 16'd30}; lid2 = {12'd7, 12'd5};
    @(negedge clk);
    lv2 = 1'b0;
    rst2 = 1'b1;
    @(negedge clk);
    chk("mrst_busy", 64'(busy2), 64'd0);
    chk("mrst_score", 64'(ms2), 64'hFFFF_FFFF);
    chk("mrst_id", 64'(mi2), 64'd0);
    chk("mrst_count", 64'(cnt2), 64'd0);
    rst2 = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done2 || rnl2 || busy2) done_cnt++;
    end
    chk("mrst_quiet", 64'(done_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
